sll_arbiter: RTL and testbench

//  Shares one 32-bit logical-left barrel shifter (sll) between NUM_REQ requesters.

---
 rtl/shift_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/sll.sv | 12 +
 rtl/sll_arbiter.sv | 97 +++++++++
 tb/tb_sll_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared widths and helpers for the shared logical-left shifter and its arbiter.
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward (mod NUM_REQ), first valid wins;
// ptr moves past the winner only when a grant is actually issued.
module rr_arbiter
  import shift_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    win,
  output logic               any
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] raw;
  logic               found;
  int unsigned        idx;

  always_comb begin
    raw   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        raw[idx] = 1'b1;
        win      = ID_W'(idx);
      end
    end
  end

  assign grant = en ? raw : '0;
  assign any   = en && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/sll.sv
// Combinational 32-bit logical left shift, zero-filled; high bits shifted out are lost.
module sll
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  y
);

  assign y = a << shamt;

endmodule

// File: rtl/sll_arbiter.sv
// Shares one sll shifter among NUM_REQ requesters: round-robin grant into S1,
// shifted result registered in S2, returned on a single id-tagged response channel.
module sll_arbiter
  import shift_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ID_W-1:0]            rsp_id
);

  logic                s1_valid, s2_valid;
  logic [DATA_W-1:0]   s1_data, s2_data, shifted, sel_data;
  logic [SHAMT_W-1:0]  s1_shamt, sel_shamt;
  logic [ID_W-1:0]     s1_id, s2_id, win;
  logic [NUM_REQ-1:0]  grant;
  logic                any, s1_adv, s2_adv, arb_en;

  assign s2_adv = !s2_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;
  // Holding arbitration off while rst_n is low keeps req_ready at zero during reset.
  assign arb_en = s1_adv && rst_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant),
    .win   (win),
    .any   (any)
  );

  assign req_ready = grant;

  // One-hot OR-mux of the granted operand.
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = sel_data  | req_data[DATA_W*i +: DATA_W];
        sel_shamt = sel_shamt | req_shamt[SHAMT_W*i +: SHAMT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_id    <= '0;
    end else if (s1_adv) begin
      s1_valid <= any;
      if (any) begin
        s1_data  <= sel_data;
        s1_shamt <= sel_shamt;
        s1_id    <= win;
      end
    end
  end

  sll u_sll (
    .a     (s1_data),
    .shamt (s1_shamt),
    .y     (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= shifted;
        s2_id   <= s1_id;
      end
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_data  = s2_data;
  assign rsp_id    = s2_id;

endmodule

// File: tb/tb_sll_arbiter.sv
// Directed bench for sll_arbiter: single-requester vector table plus
// hand-written round-robin, backpressure, pointer-wrap and reset sequences.
module tb_sll_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [19:0]  req_shamt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;

  int n_cmp  = 0;
  int n_fail = 0;

  sll_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int unsigned id, input logic [31:0] d, input logic [4:0] s);
    req_data[32*id +: 32] = d;
    req_shamt[5*id +: 5]  = s;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    mid();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_rdy[10];
    int          exp_vld[10];
    int          exp_idx[10];

    req_data  = '0;
    req_shamt = '0;

    vecs[0] = '{0, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1] = '{1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[2] = '{1, 32'h1234_5678, 5'd16, 32'h5678_0000};
    vecs[3] = '{2, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vecs[4] = '{3, 32'hA5A5_A5A5, 5'd31, 32'h8000_0000};
    vecs[5] = '{1, 32'h8000_0001, 5'd1,  32'h0000_0002};
    vecs[6] = '{0, 32'h1234_5678, 5'd4,  32'h2345_6780};

    // Reset values
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #3;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    mid();
    rst_n = 1'b1;
    cyc();

    // Single-requester vectors: ready in grant cycle, response two cycles later
    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].id, vecs[v].data, vecs[v].shamt);
      req_valid = 4'(1 << vecs[v].id);
      rsp_ready = 1'b1;
      mid();
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
      cyc();
      req_valid = '0;
      mid();
      chk($sformatf("vec%0d_early_valid", v), 32'(rsp_valid), 32'd0);
      cyc();
      mid();
      chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'd1);
      chk($sformatf("vec%0d_data", v), rsp_data, vecs[v].exp);
      chk($sformatf("vec%0d_id", v), 32'(rsp_id), vecs[v].id);
      cyc();
    end

    // All four requesters, continuous flow
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h0000_000F, 5'd4);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'((k - 2) % 4));
        chk($sformatf("rr%0d_data", k), rsp_data, 32'h0000_00F0);
      end else begin
        chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd0);
      end
      cyc();
    end

    // Backpressure for 5 cycles, then drain; per-requester data reveals ordering
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 5'd4);
    req_valid = 4'hF;
    exp_rdy = '{1, 2, 0, 0, 0, 4, 8, 1, 2, 4};
    exp_vld = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_idx = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    for (int k = 0; k < 10; k++) begin
      rsp_ready = (k >= 5);
      mid();
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'(exp_rdy[k]));
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'(exp_vld[k]));
      if (exp_vld[k] != 0) begin
        chk($sformatf("bp%0d_id", k), 32'(rsp_id), 32'(exp_idx[k]));
        chk($sformatf("bp%0d_data", k), rsp_data, 32'((exp_idx[k] + 1) << 4));
      end
      cyc();
    end

    // Pointer wrap: req3 alone, then req0+req3
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) cyc();
    set_req(0, 32'h0000_0003, 5'd2);
    set_req(3, 32'h0000_0005, 5'd1);
    req_valid = 4'b1000;
    mid();
    chk("wrap_ready3", 32'(req_ready), 32'b1000);
    cyc();
    req_valid = 4'b1001;
    mid();
    chk("wrap_ready0", 32'(req_ready), 32'b0001);
    cyc();
    mid();
    chk("wrap_ready3_again", 32'(req_ready), 32'b1000);
    chk("wrap_rsp_id3", 32'(rsp_id), 32'd3);
    chk("wrap_rsp_data3", rsp_data, 32'h0000_000A);
    cyc();
    req_valid = '0;
    mid();
    chk("wrap_rsp_id0", 32'(rsp_id), 32'd0);
    chk("wrap_rsp_data0", rsp_data, 32'h0000_000C);
    cyc();
    repeat (3) cyc();

    // Async reset with S1 and S2 full
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    mid();
    chk("fill_ready_a", 32'(req_ready), 32'b0001);
    cyc();
    mid();
    chk("fill_ready_b", 32'(req_ready), 32'b0001);
    cyc();
    mid();
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    chk("async_rsp_data", rsp_data, 32'd0);
    cyc();
    mid();
    rst_n = 1'b1;
    set_req(2, 32'h0000_0001, 5'd3);
    set_req(3, 32'h0000_0001, 5'd5);
    req_valid = 4'b1100;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready2", 32'(req_ready), 32'b0100);
    chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    cyc();
    mid();
    chk("post_rst_valid_early", 32'(rsp_valid), 32'd0);
    chk("post_rst_ready3", 32'(req_ready), 32'b1000);
    cyc();
    mid();
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_id", 32'(rsp_id), 32'd2);
    chk("post_rst_data", rsp_data, 32'h0000_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
